// File: rtl/reset_sequencer.sv
// Reset sequencer: holds every downstream stage in reset, then releases the
// stages one at a time in index order. Each release waits for that stage's
// acknowledge, with an optional idle gap before the next release.
// A missing acknowledge parks the sequencer in FAULT until a soft start.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int ACK_TIMEOUT = 255,
  parameter int GAP_CYCLES  = 2,
  localparam int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic [STAGE_W-1:0]    cur_stage,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [STAGE_W-1:0]    err_stage
);

  // A single down-counter serves the hold, timeout and gap phases, so it is
  // sized for the longest of the three.
  localparam int CNT_MAX_HT = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_HT > GAP_CYCLES) ? CNT_MAX_HT : GAP_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  // Each phase loads N-1 and leaves when the counter reads zero, giving N cycles.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LOAD  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_ACK,
    S_GAP,
    S_FAULT
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   stage_reset_q, stage_reset_d;
  logic [STAGE_W-1:0]      cur_stage_q, cur_stage_d;
  logic                    done_q, done_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [STAGE_W-1:0]      err_stage_q, err_stage_d;
  logic [STAGE_W-1:0]      next_stage;

  assign next_stage = cur_stage_q + 1'b1;

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    stage_reset_d = stage_reset_q;
    cur_stage_d   = cur_stage_q;
    done_d        = 1'b0;
    timeout_err_d = timeout_err_q;
    err_stage_d   = err_stage_q;

    case (state_q)
      S_IDLE, S_FAULT: begin
        // Soft start restarts the whole sequence with a fresh hold period.
        if (start) begin
          state_d       = S_ASSERT;
          cnt_d         = HOLD_LOAD;
          stage_reset_d = '1;
          cur_stage_d   = '0;
          timeout_err_d = 1'b0;
        end
      end

      S_ASSERT: begin
        if (cnt_q == '0) begin
          state_d          = S_WAIT_ACK;
          cnt_d            = ACK_LOAD;
          cur_stage_d      = '0;
          stage_reset_d[0] = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_WAIT_ACK: begin
        // The acknowledge is tested before the timeout so that an ack on the
        // final allowed cycle still counts as success.
        if (stage_ack[cur_stage_q]) begin
          if (cur_stage_q == LAST_STAGE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (GAP_CYCLES == 0) begin
            cnt_d                     = ACK_LOAD;
            cur_stage_d               = next_stage;
            stage_reset_d[next_stage] = 1'b0;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else if (cnt_q == '0) begin
          state_d                    = S_FAULT;
          stage_reset_d[cur_stage_q] = 1'b1;
          timeout_err_d              = 1'b1;
          err_stage_d                = cur_stage_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          state_d                   = S_WAIT_ACK;
          cnt_d                     = ACK_LOAD;
          cur_stage_d               = next_stage;
          stage_reset_d[next_stage] = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; synchronous reset starts a power-up sequence.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (reset) begin
      // NOTE: this block holds only control registers, no storage arrays,
      // so every flop is reset to a known value.
      state_q       <= S_ASSERT;
      cnt_q         <= HOLD_LOAD;
      stage_reset_q <= '1;
      cur_stage_q   <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      err_stage_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stage_reset_q <= stage_reset_d;
      cur_stage_q   <= cur_stage_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      err_stage_q   <= err_stage_d;
    end
  end

  assign stage_reset = stage_reset_q;
  assign cur_stage   = cur_stage_q;
  assign busy        = (state_q == S_ASSERT) || (state_q == S_WAIT_ACK) || (state_q == S_GAP);
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign err_stage   = err_stage_q;

endmodule
